// File: rtl/score_keeper.sv
// Scoring engine: turns line-clear events into a saturating score, line total and level.
// Points are built by repeated addition (level+1 adds of the base value), so no multiplier.
module score_keeper #(
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_SCORE       = 9999,
    parameter int unsigned MAX_LEVEL       = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_start,
    input  logic        clear_valid,
    input  logic [2:0]  clear_count,
    output logic        clear_ready,
    output logic [15:0] score,
    output logic [7:0]  lines,
    output logic [3:0]  level,
    output logic        score_update
);

    typedef enum logic [1:0] {StIdle, StAccum, StUpdate} state_e;

    localparam logic [8:0]  Lpl      = 9'(LINES_PER_LEVEL);
    localparam logic [16:0] MaxScore = 17'(MAX_SCORE);
    localparam logic [3:0]  MaxLevel = 4'(MAX_LEVEL);

    state_e      state_q, state_d;
    logic [10:0] base_q, base_d;
    logic [2:0]  count_q, count_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  lines_q, lines_d;
    logic [3:0]  level_q, level_d;
    // Bit 8 is always zero in state; the width keeps the wrap-around arithmetic exact.
    logic [8:0]  lil_q, lil_d;
    logic        update_q, update_d;

    logic [16:0] score_sum;
    logic [8:0]  lines_sum;
    logic [8:0]  lil_sum;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        lines_d   = lines_q;
        level_d   = level_q;
        lil_d     = lil_q;
        update_d  = 1'b0;

        score_sum = {1'b0, score_q} + {6'd0, base_q};
        lines_sum = {1'b0, lines_q} + {6'd0, count_q};
        lil_sum   = lil_q + {6'd0, count_q};

        if (game_start) begin
            state_d = StIdle;
            score_d = '0;
            lines_d = '0;
            level_d = '0;
            lil_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clear_valid) begin
                        // Out-of-range counts run the full sequence with zero points and lines.
                        unique case (clear_count)
                            3'd1:    begin base_d = 11'd40;   count_d = 3'd1; end
                            3'd2:    begin base_d = 11'd100;  count_d = 3'd2; end
                            3'd3:    begin base_d = 11'd300;  count_d = 3'd3; end
                            3'd4:    begin base_d = 11'd1200; count_d = 3'd4; end
                            default: begin base_d = 11'd0;    count_d = 3'd0; end
                        endcase
                        cnt_d   = level_q;
                        state_d = StAccum;
                    end
                end
                StAccum: begin
                    score_d = (score_sum > MaxScore) ? MaxScore[15:0] : score_sum[15:0];
                    if (cnt_q == 4'd0) begin
                        state_d = StUpdate;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StUpdate: begin
                    lines_d = lines_sum[8] ? 8'd255 : lines_sum[7:0];
                    if (lil_sum >= Lpl) begin
                        lil_d   = lil_sum - Lpl;
                        level_d = (level_q >= MaxLevel) ? level_q : level_q + 4'd1;
                    end else begin
                        lil_d = lil_sum;
                    end
                    update_d = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            base_q   <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            score_q  <= '0;
            lines_q  <= '0;
            level_q  <= '0;
            lil_q    <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            lines_q  <= lines_d;
            level_q  <= level_d;
            lil_q    <= lil_d;
            update_q <= update_d;
        end
    end

    assign clear_ready  = (state_q == StIdle);
    assign score        = score_q;
    assign lines        = lines_q;
    assign level        = level_q;
    assign score_update = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: vector table of back-to-back events plus
// hand-written sequences for game_start abort, saturation and async reset.
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        game_start;
    logic        clear_valid;
    logic [2:0]  clear_count;
    logic        clear_ready;
    logic [15:0] score;
    logic [7:0]  lines;
    logic [3:0]  level;
    logic        score_update;

    score_keeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_start   (game_start),
        .clear_valid  (clear_valid),
        .clear_count  (clear_count),
        .clear_ready  (clear_ready),
        .score        (score),
        .lines        (lines),
        .level        (level),
        .score_update (score_update)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] cnt;
        int         exp_score;
        int         exp_lines;
        int         exp_level;
        int         exp_busy;
    } vec_t;

    vec_t vecs[18];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one event and waits (bounded) for clear_ready to return.
    task automatic send(input logic [2:0] c, output int busy, output int upd_at_accept);
        clear_valid = 1'b1;
        clear_count = c;
        tick();
        clear_valid   = 1'b0;
        upd_at_accept = int'(score_update);
        busy = 0;
        while (!clear_ready && busy < 40) begin
            busy++;
            tick();
        end
    endtask

    initial begin
        int busy;
        int upd0;
        int n_upd;
        int wrapped;
        int prev;

        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        game_start  = 1'b0;
        clear_valid = 1'b0;
        clear_count = 3'd0;

        for (int k = 1; k <= 10; k++) vecs[k-1] = '{3'd1, 40 * k, k, (k == 10) ? 1 : 0, 2};
        vecs[10] = '{3'd4, 2800,  14, 1, 3};
        vecs[11] = '{3'd0, 2800,  14, 1, 3};
        vecs[12] = '{3'd7, 2800,  14, 1, 3};
        vecs[13] = '{3'd3, 3400,  17, 1, 3};
        vecs[14] = '{3'd1, 3480,  18, 1, 3};
        vecs[15] = '{3'd3, 4080,  21, 2, 3};
        vecs[16] = '{3'd2, 4380,  23, 2, 4};
        vecs[17] = '{3'd4, 7980,  27, 2, 4};

        #12;
        check("reset score", int'(score), 0);
        check("reset lines", int'(lines), 0);
        check("reset level", int'(level), 0);
        check("reset update", int'(score_update), 0);
        check("reset ready", int'(clear_ready), 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].cnt, busy, upd0);
            check($sformatf("vec%0d upd_at_accept", i), upd0, 0);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d update", i), int'(score_update), 1);
            check($sformatf("vec%0d score", i), int'(score), vecs[i].exp_score);
            check($sformatf("vec%0d lines", i), int'(lines), vecs[i].exp_lines);
            check($sformatf("vec%0d level", i), int'(level), vecs[i].exp_level);
        end

        // 7980 + 3*1200 saturates; lil 7+4=11 steps to level 3.
        send(3'd4, busy, upd0);
        check("sat1 busy", busy, 4);
        check("sat1 score", int'(score), 9999);
        check("sat1 level", int'(level), 3);
        check("sat1 lines", int'(lines), 31);
        send(3'd4, busy, upd0);
        check("sat2 busy", busy, 5);
        check("sat2 update", int'(score_update), 1);
        check("sat2 score", int'(score), 9999);
        check("sat2 lines", int'(lines), 35);

        // game_start during ACCUM, with a simultaneous clear_valid.
        tick();
        clear_valid = 1'b1;
        clear_count = 3'd4;
        tick();
        clear_valid = 1'b0;
        tick();
        check("gs pre ready", int'(clear_ready), 0);
        game_start  = 1'b1;
        clear_valid = 1'b1;
        clear_count = 3'd1;
        tick();
        game_start  = 1'b0;
        clear_valid = 1'b0;
        check("gs score", int'(score), 0);
        check("gs lines", int'(lines), 0);
        check("gs level", int'(level), 0);
        check("gs ready", int'(clear_ready), 1);
        n_upd = 0;
        for (int c = 0; c < 8; c++) begin
            if (score_update || !clear_ready) n_upd++;
            tick();
        end
        check("gs no update/accept", n_upd, 0);

        send(3'd1, busy, upd0);
        check("post gs busy", busy, 2);
        check("post gs score", int'(score), 40);
        check("post gs lines", int'(lines), 1);

        // Tetrises up to the level and line ceilings.
        n_upd   = 0;
        wrapped = 0;
        prev    = int'(score);
        for (int t = 0; t < 64; t++) begin
            send(3'd4, busy, upd0);
            if (score_update) n_upd++;
            if (int'(score) < prev || int'(score) > 9999) wrapped++;
            prev = int'(score);
        end
        check("ceil updates", n_upd, 64);
        check("ceil no wrap", wrapped, 0);
        check("ceil score", int'(score), 9999);
        check("ceil lines", int'(lines), 255);
        check("ceil level", int'(level), 15);
        send(3'd4, busy, upd0);
        check("ceil busy", busy, 17);
        check("ceil level hold", int'(level), 15);

        // Asynchronous reset mid-ACCUM, between clock edges.
        clear_valid = 1'b1;
        clear_count = 3'd2;
        tick();
        clear_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst score", int'(score), 0);
        check("arst lines", int'(lines), 0);
        check("arst level", int'(level), 0);
        check("arst ready", int'(clear_ready), 1);
        check("arst update", int'(score_update), 0);
        #10;
        rst_n = 1'b1;
        tick();
        send(3'd2, busy, upd0);
        check("after arst score", int'(score), 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
